// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions: fetch FSM encoding, halt opcode, reset PC and
// instruction field positions.
package fetch_stage_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        WAIT   = 3'd1,
        HOLD   = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } fetch_state_e;

    localparam logic [3:0]  OPC_HLT      = 4'hF;
    localparam logic [15:0] CPU_RESET_PC = 16'h0000;
    localparam int unsigned OPC_MSB      = 15;
    localparam int unsigned OPC_LSB      = 12;

    function automatic logic [3:0] opcode(input logic [15:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register with valid bit; clear drops the valid bit,
// load captures a new entry, otherwise the entry holds.
module ifid_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC ownership, variable-latency imem handshake,
// one-entry skid buffer behind IF/ID, redirect squash and halt detection.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = CPU_RESET_PC,
    parameter logic [15:0] PC_INC   = 16'd2,
    parameter logic [3:0]  HALT_OPC = OPC_HLT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        ifid_valid,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_npc,
    output logic [15:0] pc,
    output logic        halted
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  addr_q, addr_d;
    logic         halted_q, halted_d;
    logic         skid_valid_q, skid_valid_d;
    logic [15:0]  skid_instr_q, skid_instr_d;
    logic [15:0]  skid_npc_q, skid_npc_d;

    logic         ifid_load, ifid_clear;
    logic [31:0]  ifid_in, ifid_data;

    logic [15:0]  npc;
    logic         fetching, fetch_done, slot_free, is_halt, skid_halt;

    assign npc        = pc_q + PC_INC;
    assign fetching   = (state_q == FETCH) || (state_q == WAIT);
    assign fetch_done = fetching && imem_rdy && !redirect;
    assign slot_free  = !ifid_valid || !id_stall;
    assign is_halt    = (opcode(imem_data) == HALT_OPC);
    assign skid_halt  = (opcode(skid_instr_q) == HALT_OPC);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect pre-empts every state
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            if ((fetching || state_q == DRAIN) && !imem_rdy) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
            end
        end else begin
            case (state_q)
                FETCH, WAIT: begin
                    if (imem_rdy) begin
                        if (!slot_free)   state_d = HOLD;
                        else if (is_halt) state_d = HALTED;
                        else              state_d = FETCH;
                    end else begin
                        state_d = WAIT;
                    end
                end
                HOLD: begin
                    if (!id_stall) state_d = skid_halt ? HALTED : FETCH;
                end
                DRAIN: begin
                    if (imem_rdy) state_d = FETCH;
                end
                HALTED:  state_d = HALTED;
                default: state_d = FETCH;
            endcase
        end
    end

    // Memory interface outputs; DRAIN keeps presenting the squashed address
    always_comb begin
        imem_req  = !rst && (fetching || state_q == DRAIN);
        imem_addr = (state_q == DRAIN) ? addr_q : pc_q;
    end

    // Datapath: PC, halt flag, skid buffer and IF/ID controls
    always_comb begin
        pc_d         = pc_q;
        addr_d       = (state_q == DRAIN) ? addr_q : pc_q;
        halted_d     = halted_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_npc_d   = skid_npc_q;
        ifid_load    = 1'b0;
        ifid_clear   = 1'b0;
        ifid_in      = {imem_data, npc};
        if (redirect) begin
            pc_d         = redirect_pc;
            halted_d     = 1'b0;
            skid_valid_d = 1'b0;
            ifid_clear   = 1'b1;
        end else begin
            if (fetch_done) begin
                pc_d = npc;
                if (is_halt) halted_d = 1'b1;
                if (slot_free) begin
                    ifid_load = 1'b1;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_instr_d = imem_data;
                    skid_npc_d   = npc;
                end
            end else if (state_q == HOLD && skid_valid_q && !id_stall) begin
                ifid_load    = 1'b1;
                ifid_in      = {skid_instr_q, skid_npc_q};
                skid_valid_d = 1'b0;
            end
            if (!ifid_load && !id_stall) ifid_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            halted_q     <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_npc_q   <= '0;
        end else begin
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            halted_q     <= halted_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_npc_q   <= skid_npc_d;
        end
    end

    ifid_reg #(
        .WIDTH(32)
    ) u_ifid (
        .clk     (clk),
        .rst     (rst),
        .load    (ifid_load),
        .clear   (ifid_clear),
        .data_in (ifid_in),
        .valid   (ifid_valid),
        .data    (ifid_data)
    );

    assign ifid_instr = ifid_data[31:16];
    assign ifid_npc   = ifid_data[15:0];
    assign pc         = pc_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural variable-latency memory plus a
// scoreboard of IF/ID entries checked as decode consumes them.
module tb_fetch_stage;

    logic        clk, rst;
    logic        imem_req, imem_rdy;
    logic [15:0] imem_addr, imem_data;
    logic        id_stall, redirect;
    logic [15:0] redirect_pc;
    logic        ifid_valid, halted;
    logic [15:0] ifid_instr, ifid_npc, pc;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] npc;
    } ent_t;
    ent_t exp_q[$];

    logic        mem_on, ovr_en;
    logic [15:0] ovr_addr, ovr_data;
    int unsigned lat, cnt;

    fetch_stage #(
        .RESET_PC(16'h0000),
        .PC_INC  (16'd2),
        .HALT_OPC(4'hF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdy   (imem_rdy),
        .imem_data  (imem_data),
        .id_stall   (id_stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_npc   (ifid_npc),
        .pc         (pc),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers after `lat` waiting cycles; content is 16'h1000+addr
    // unless the single override location matches.
    always_comb begin
        imem_rdy  = imem_req && mem_on && (cnt >= lat);
        imem_data = (ovr_en && imem_addr == ovr_addr) ? ovr_data : 16'h1000 + imem_addr;
    end

    always @(posedge clk) begin
        if (rst || !imem_req || imem_rdy || !mem_on) cnt <= 0;
        else                                          cnt <= cnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] instr, input logic [15:0] npc);
        exp_q.push_back('{instr: instr, npc: npc});
    endtask

    // An entry is consumed on an edge where it is valid and decode is not stalled
    always @(negedge clk) begin
        if (!rst && ifid_valid && !id_stall) begin
            ent_t e;
            compared++;
            assert (exp_q.size() != 0) else begin
                mismatched++;
                $error("FAIL sb_unexpected: observed instr %h npc %h expected no entry", ifid_instr, ifid_npc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_instr", ifid_instr, e.instr);
                chk("sb_npc", ifid_npc, e.npc);
            end
        end
    end

    initial begin
        logic [15:0] lat_addr[6];
        logic        lat_valid[6];
        lat_addr  = '{16'h0006, 16'h0006, 16'h0008, 16'h0008, 16'h0008, 16'h000A};
        lat_valid = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; id_stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        mem_on = 1'b0; ovr_en = 1'b0; ovr_addr = 16'h0000; ovr_data = 16'h0000; lat = 0;
        tick();
        tick();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_valid", {15'd0, ifid_valid}, 16'd0);
        chk("rst_instr", ifid_instr, 16'h0000);
        chk("rst_npc", ifid_npc, 16'h0000);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_req", {15'd0, imem_req}, 16'd0);

        // Sequential fetch, zero latency
        mem_on = 1'b1;
        push(16'h1000, 16'h0002);
        push(16'h1002, 16'h0004);
        push(16'h1004, 16'h0006);
        rst = 1'b0;
        tick();
        chk("seq_valid0", {15'd0, ifid_valid}, 16'd1);
        chk("seq_instr0", ifid_instr, 16'h1000);
        chk("seq_npc0", ifid_npc, 16'h0002);
        tick();
        chk("seq_instr1", ifid_instr, 16'h1002);
        chk("seq_pc1", pc, 16'h0004);
        tick();
        chk("seq_instr2", ifid_instr, 16'h1004);
        chk("seq_npc2", ifid_npc, 16'h0006);
        chk("seq_pc2", pc, 16'h0006);
        mem_on = 1'b0;
        tick();
        chk("wait_valid", {15'd0, ifid_valid}, 16'd0);
        chk("wait_req", {15'd0, imem_req}, 16'd1);
        chk("wait_addr", imem_addr, 16'h0006);

        // Latency: ready two cycles after the request starts
        lat = 2;
        mem_on = 1'b1;
        push(16'h1006, 16'h0008);
        push(16'h1008, 16'h000A);
        for (int unsigned c = 0; c < 6; c++) begin
            tick();
            chk("lat_addr", imem_addr, lat_addr[c]);
            chk("lat_valid", {15'd0, ifid_valid}, {15'd0, lat_valid[c]});
            chk("lat_pc", pc, lat_addr[c]);
        end

        // Stall while the next fetch completes: instruction parks in the skid
        id_stall = 1'b1;
        push(16'h100A, 16'h000C);
        tick();
        tick();
        chk("stall_hold_instr", ifid_instr, 16'h1008);
        chk("stall_req_wait", {15'd0, imem_req}, 16'd1);
        tick();
        chk("hold_req", {15'd0, imem_req}, 16'd0);
        chk("hold_instr", ifid_instr, 16'h1008);
        chk("hold_pc", pc, 16'h000C);
        tick();
        chk("hold_req2", {15'd0, imem_req}, 16'd0);
        chk("hold_npc", ifid_npc, 16'h000A);
        id_stall = 1'b0;
        mem_on = 1'b0;
        tick();
        chk("skid_instr", ifid_instr, 16'h100A);
        chk("skid_npc", ifid_npc, 16'h000C);
        chk("skid_valid", {15'd0, ifid_valid}, 16'd1);
        chk("skid_addr", imem_addr, 16'h000C);
        tick();
        chk("pre_redir_valid", {15'd0, ifid_valid}, 16'd0);
        chk("pre_redir_addr", imem_addr, 16'h000C);

        // Redirect while waiting: old request drains, then fetch from target
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        chk("drain_req", {15'd0, imem_req}, 16'd1);
        chk("drain_addr", imem_addr, 16'h000C);
        chk("drain_pc", pc, 16'h0040);
        chk("drain_valid", {15'd0, ifid_valid}, 16'd0);
        mem_on = 1'b1;
        lat = 0;
        push(16'h1040, 16'h0042);
        tick();
        chk("post_drain_valid", {15'd0, ifid_valid}, 16'd0);
        chk("post_drain_addr", imem_addr, 16'h0040);
        tick();
        chk("tgt_instr", ifid_instr, 16'h1040);
        chk("tgt_npc", ifid_npc, 16'h0042);
        chk("tgt_pc", pc, 16'h0042);

        // Redirect coinciding with ready drops the returned word; then halt
        redirect = 1'b1;
        redirect_pc = 16'h0008;
        ovr_en = 1'b1;
        ovr_addr = 16'h0008;
        ovr_data = 16'hF000;
        push(16'hF000, 16'h000A);
        tick();
        redirect = 1'b0;
        chk("redir_rdy_valid", {15'd0, ifid_valid}, 16'd0);
        chk("redir_rdy_pc", pc, 16'h0008);
        chk("redir_rdy_addr", imem_addr, 16'h0008);
        tick();
        chk("halt_instr", ifid_instr, 16'hF000);
        chk("halt_npc", ifid_npc, 16'h000A);
        chk("halt_flag", {15'd0, halted}, 16'd1);
        chk("halt_pc", pc, 16'h000A);
        for (int unsigned c = 0; c < 20; c++) begin
            tick();
            chk("halted_req", {15'd0, imem_req}, 16'd0);
        end
        chk("halted_pc", pc, 16'h000A);
        chk("halted_flag", {15'd0, halted}, 16'd1);
        chk("halted_drained", {15'd0, ifid_valid}, 16'd0);

        // Redirect out of HALTED to the top of memory; PC wraps
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        ovr_addr = 16'hFFFE;
        ovr_data = 16'h2000;
        push(16'h2000, 16'h0000);
        tick();
        redirect = 1'b0;
        chk("resume_halted", {15'd0, halted}, 16'd0);
        chk("resume_req", {15'd0, imem_req}, 16'd1);
        chk("resume_addr", imem_addr, 16'hFFFE);
        chk("resume_pc", pc, 16'hFFFE);
        tick();
        chk("wrap_instr", ifid_instr, 16'h2000);
        chk("wrap_npc", ifid_npc, 16'h0000);
        chk("wrap_pc", pc, 16'h0000);
        mem_on = 1'b0;
        tick();
        tick();

        compared++;
        assert (exp_q.size() == 0) else begin
            mismatched++;
            $error("FAIL sb_leftover: observed %0d entries pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the 16-bit CPU.
- Owns the PC and issues requests to a variable-latency instruction memory.
- Delivers fetched instructions plus PC+2 into an IF/ID register consumed by decode.
- Handles downstream stall (one-entry skid buffer), branch/jump redirect with in-flight squash, and halt detection (opcode 4'hF).

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- PC_INC, 2, byte increment per sequential instruction
- HALT_OPC, 4'hF, opcode (instr[15:12]) that stops fetching

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held until accepted
- imem_addr  out  16  fetch address; stable while imem_req high
- imem_rdy  in  1  imem_data valid this cycle; may assert in the same cycle as imem_req
- imem_data  in  16  returned instruction
- id_stall  in  1  decode cannot accept a new IF/ID entry
- redirect  in  1  single-cycle pulse: squash and fetch from redirect_pc
- redirect_pc  in  16  branch/jump target
- ifid_valid  out  1  IF/ID entry valid
- ifid_instr  out  16  IF/ID instruction
- ifid_npc  out  16  IF/ID PC+PC_INC of that instruction
- pc  out  16  current fetch PC
- halted  out  1  high once a HALT_OPC instruction has been captured

Behaviour:
- Reset (clk edge with rst=1):
  - pc=RESET_PC; state=FETCH; ifid_valid=0; ifid_instr=0; ifid_npc=0; halted=0; skid empty; imem_req=0 in the reset cycle.
- FSM states: FETCH, WAIT, HOLD, DRAIN, HALTED.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Fetch completes on the cycle with imem_rdy=1; otherwise go to WAIT (request and address held).
- WAIT:
  - imem_req=1, imem_addr unchanged.
  - Fetch completes when imem_rdy=1.
- Fetch completion in FETCH or WAIT:
  - pc <= pc+PC_INC, with 16-bit wrap (16'hFFFE -> 16'h0000).
  - If the IF/ID slot is free (ifid_valid=0, or id_stall=0): load IF/ID {1, imem_data, pc+PC_INC}.
  - Otherwise: write the instruction into the skid buffer and go to HOLD.
  - If imem_data[15:12]==HALT_OPC: halted<=1, next state is HALTED (via HOLD if skid used); pc holds at the halt instruction's pc+PC_INC.
  - Otherwise: next state is FETCH.
- HOLD:
  - No request issued.
  - When id_stall=0: skid moves to IF/ID; next state is FETCH, or HALTED if the skid entry is the halt.
- IF/ID register:
  - When id_stall=1 and no redirect, ifid_* hold.
  - When id_stall=0 and nothing new to load, ifid_valid<=0.
  - Throughput: one instruction per cycle when imem_rdy is always 1 and id_stall=0.
- Redirect (priority over everything except rst):
  - pc <= redirect_pc; ifid_valid<=0; skid cleared; halted<=0.
  - If a request is outstanding without imem_rdy this cycle (WAIT, or FETCH with imem_rdy=0): next state DRAIN.
  - Otherwise: next state FETCH.
  - Redirect in HALTED resumes fetching, because an older branch can squash a halt.
- DRAIN:
  - imem_req=1, imem_addr = old address.
  - On imem_rdy the data is discarded; next state FETCH.
  - A second redirect in DRAIN updates pc only.
- HALTED: imem_req=0; pc and halted hold; IF/ID drains normally per id_stall.
- Simultaneous redirect and imem_rdy: returned data discarded; no IF/ID load.
- rst mid-operation: immediate return to reset values; an outstanding memory response after reset is not expected (memory shares rst).
- Widths: all datapath values are 16-bit unsigned; the PC increment drops the carry.

Decomposition:
- Shared cpu package holds:
  - fetch state enum (FETCH, WAIT, HOLD, DRAIN, HALTED), 3-bit encoding;
  - OPC_HLT=4'hF;
  - RESET_PC;
  - instruction field slice constants (opcode [15:12]).
- One sub-module, ifid_reg: the IF/ID pipeline register with load/hold/clear controls. It is reused for later pipeline registers.

Test Plan:
- Sequential fetch: rst 1 cycle, imem_rdy=1 always, memory returns 16'h1000+addr → ifid_instr 16'h1000,16'h1002,16'h1004 on consecutive cycles; ifid_npc=2,4,6; pc ends 6 after 3 fetches.
- Latency 3: imem_rdy asserted 2 cycles after imem_req → imem_addr stable 3 cycles; one ifid_valid pulse per 3 cycles; pc steps by 2 each completion.
- Stall plus skid: id_stall=1 for 4 cycles while a fetch completes → IF/ID holds the old entry, the new instruction sits in the skid, imem_req=0 in HOLD; when id_stall drops the skid appears next cycle with correct npc.
- Redirect in WAIT: redirect=1, redirect_pc=16'h0040 while waiting → old data dropped in DRAIN, ifid_valid=0, next imem_addr=16'h0040.
- Halt: memory returns 16'hF000 at addr 16'h0008 → ifid_instr=16'hF000, halted=1, pc=16'h000A, imem_req stays 0 for 20 cycles.
- Redirect while HALTED plus pc wrap: redirect_pc=16'hFFFE, instruction 16'h2000 → halted=0, fetch at 16'hFFFE, then pc=16'h0000.
